// File: rtl/uart_pkg.sv
// Shared types and constants for the UART core.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Literals are prefixed because both enums live in one scope
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tTxState;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } tRxState;

  // Parity bit for a word (zero-extended to 9 bits): even = ^data, odd = ~^data
  function automatic logic parityBit(input logic [8:0] data, input int mode);
    return (^data) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter. Ticks on the last cycle of each bit period while
// running and reloads itself, so consecutive bits need no reload.
module uart_bit_timer #(
  parameter int CLK_DIV = 434
) (
  input  logic                       ipClk,
  input  logic                       nReset,
  input  logic                       ipLoad,
  input  logic [$clog2(CLK_DIV)-1:0] ipLoadVal,
  input  logic                       ipRun,
  output logic                       opTick
);

  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] RELOAD = TW'(CLK_DIV - 1);

  logic [TW-1:0] cnt;

  // Tick does not depend on ipLoad: TX readiness is derived from the tick and
  // the load is derived from readiness, so gating would form a loop.
  assign opTick = ipRun && (cnt == '0);

  // Count down while running; load takes priority for the phase of a new frame
  always_ff @(posedge ipClk) begin
    if (nReset)          cnt <= '0;
    else if (ipLoad)     cnt <= ipLoadVal;
    else if (ipRun)      cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: valid/ready TX, RX with parity/framing error flags and
// false-start rejection. TX and RX share only the clock and reset.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 434,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 ipClk,
  input  logic                 nReset,
  input  logic [DATA_BITS-1:0] ipTxData,
  input  logic                 ipTxValid,
  output logic                 opTxReady,
  output logic                 opTx,
  input  logic                 ipRx,
  output logic [DATA_BITS-1:0] opRxData,
  output logic                 opRxValid,
  output logic                 opRxParityErr,
  output logic                 opRxFrameErr
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  generate
    if (CLK_DIV < 8 || CLK_DIV > 65535) begin : gBadDiv
      $error("uart_core: CLK_DIV must be 8..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadData
      $error("uart_core: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : gBadPar
      $error("uart_core: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStop
      $error("uart_core: STOP_BITS must be 1 or 2");
    end
  endgenerate

  // ---------------------------------------------------------------- TX
  tTxState               txState, txNext;
  logic [DATA_BITS-1:0]  txShift;
  logic                  txPar;
  logic [BW-1:0]         txBitCnt;
  logic                  txStopCnt;
  logic                  txTick, txFire, txLastStop, txOut;

  assign txLastStop = (txState == TX_STOP) && txTick &&
                      (txStopCnt == 1'(STOP_BITS - 1));
  // Ready in the last STOP cycle lets the next start bit follow with no gap
  assign opTxReady  = !nReset && ((txState == TX_IDLE) || txLastStop);
  assign txFire     = ipTxValid && opTxReady;
  assign opTx       = nReset ? 1'b1 : txOut;

  uart_bit_timer #(.CLK_DIV(CLK_DIV)) uTxTimer (
    .ipClk    (ipClk),
    .nReset   (nReset),
    .ipLoad   (txFire),
    .ipLoadVal(BIT_LAST),
    .ipRun    (txState != TX_IDLE),
    .opTick   (txTick)
  );

  // TX state register
  always_ff @(posedge ipClk) begin
    if (nReset) txState <= TX_IDLE;
    else        txState <= txNext;
  end

  // TX next state and serial output level
  always_comb begin
    txNext = txState;
    txOut  = 1'b1;
    case (txState)
      TX_IDLE:   if (txFire) txNext = TX_START;
      TX_START: begin
        txOut = 1'b0;
        if (txTick) txNext = TX_DATA;
      end
      TX_DATA: begin
        txOut = txShift[0];
        if (txTick && txBitCnt == DATA_LAST)
          txNext = (PARITY != PARITY_NONE) ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        txOut = txPar;
        if (txTick) txNext = TX_STOP;
      end
      TX_STOP:   if (txLastStop) txNext = txFire ? TX_START : TX_IDLE;
      default:   txNext = TX_IDLE;
    endcase
  end

  // TX datapath: latch on handshake, shift LSB first, count data and stop bits
  always_ff @(posedge ipClk) begin
    if (nReset) begin
      txShift   <= '0;
      txPar     <= 1'b0;
      txBitCnt  <= '0;
      txStopCnt <= 1'b0;
    end else if (txFire) begin
      txShift   <= ipTxData;
      txPar     <= parityBit(9'(ipTxData), PARITY);
      txBitCnt  <= '0;
      txStopCnt <= 1'b0;
    end else if (txTick) begin
      if (txState == TX_DATA) begin
        txShift  <= txShift >> 1;
        txBitCnt <= txBitCnt + 1'b1;
      end
      if (txState == TX_STOP && !txLastStop)
        txStopCnt <= txStopCnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- RX
  tRxState               rxState, rxNext;
  logic                  rxMeta, rxS, rxSd;
  logic [DATA_BITS-1:0]  rxShift;
  logic [BW-1:0]         rxBitCnt;
  logic                  rxParErr;
  logic                  rxTick, rxStartEdge, rxRun;

  assign rxStartEdge = (rxState == RX_IDLE) && rxSd && !rxS;
  assign rxRun       = (rxState != RX_IDLE) && (rxState != RX_WAIT_HIGH);

  // Two-flop synchroniser plus one delay stage for falling-edge detection
  always_ff @(posedge ipClk) begin
    if (nReset) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
      rxSd   <= 1'b1;
    end else begin
      rxMeta <= ipRx;
      rxS    <= rxMeta;
      rxSd   <= rxS;
    end
  end

  // Half-bit load on the start edge puts every later tick at mid-bit
  uart_bit_timer #(.CLK_DIV(CLK_DIV)) uRxTimer (
    .ipClk    (ipClk),
    .nReset   (nReset),
    .ipLoad   (rxStartEdge),
    .ipLoadVal(HALF_LAST),
    .ipRun    (rxRun),
    .opTick   (rxTick)
  );

  // RX state register
  always_ff @(posedge ipClk) begin
    if (nReset) rxState <= RX_IDLE;
    else        rxState <= rxNext;
  end

  // RX next state: reject false starts, park in WAIT_HIGH after a low stop bit
  always_comb begin
    rxNext = rxState;
    case (rxState)
      RX_IDLE:      if (rxStartEdge) rxNext = RX_START;
      RX_START:     if (rxTick) rxNext = rxS ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (rxTick && rxBitCnt == DATA_LAST)
          rxNext = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
      RX_PARITY:    if (rxTick) rxNext = RX_STOP;
      RX_STOP:      if (rxTick) rxNext = rxS ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rxS) rxNext = RX_IDLE;
      default:      rxNext = RX_IDLE;
    endcase
  end

  // RX datapath: shift in at mid-bit, deliver word and flags on the stop sample
  always_ff @(posedge ipClk) begin
    if (nReset) begin
      rxShift       <= '0;
      rxBitCnt      <= '0;
      rxParErr      <= 1'b0;
      opRxData      <= '0;
      opRxValid     <= 1'b0;
      opRxParityErr <= 1'b0;
      opRxFrameErr  <= 1'b0;
    end else begin
      opRxValid     <= 1'b0;
      opRxParityErr <= 1'b0;
      opRxFrameErr  <= 1'b0;
      if (rxStartEdge) begin
        rxBitCnt <= '0;
        rxParErr <= 1'b0;
      end else if (rxTick) begin
        case (rxState)
          RX_DATA: begin
            rxShift  <= {rxS, rxShift[DATA_BITS-1:1]};
            rxBitCnt <= rxBitCnt + 1'b1;
          end
          RX_PARITY: rxParErr <= rxS ^ parityBit(9'(rxShift), PARITY);
          RX_STOP: begin
            opRxData      <= rxShift;
            opRxValid     <= 1'b1;
            opRxParityErr <= rxParErr;
            opRxFrameErr  <= !rxS;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench: three instances (8N1 direct, 8E2 looped back, 7O1 direct).
module tb_uart_core;

  localparam int DIV = 16;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] rxLine;
  int         cyc = 0;
  int         nChk = 0;
  int         nPass = 0;
  int         pulses [3];
  exp_t       qA [$];
  exp_t       qB [$];
  exp_t       qC [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: 8N1, serial input selectable between bench line and own TX
  logic [7:0] aTxData, aRxData;
  logic       aTxValid, aTxReady, aTx, aRx, aRxValid, aRxPe, aRxFe, aLoop;
  assign aRx = aLoop ? aTx : rxLine[0];

  uart_core #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) uA (
    .ipClk(clk), .nReset(rst), .ipTxData(aTxData), .ipTxValid(aTxValid),
    .opTxReady(aTxReady), .opTx(aTx), .ipRx(aRx), .opRxData(aRxData),
    .opRxValid(aRxValid), .opRxParityErr(aRxPe), .opRxFrameErr(aRxFe));

  // Instance B: 8E2 with TX looped into RX
  logic [7:0] bTxData, bRxData;
  logic       bTxValid, bTxReady, bTx, bRxValid, bRxPe, bRxFe;

  uart_core #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) uB (
    .ipClk(clk), .nReset(rst), .ipTxData(bTxData), .ipTxValid(bTxValid),
    .opTxReady(bTxReady), .opTx(bTx), .ipRx(bTx), .opRxData(bRxData),
    .opRxValid(bRxValid), .opRxParityErr(bRxPe), .opRxFrameErr(bRxFe));

  // Instance C: 7O1, RX driven by the bench, TX never used
  logic [6:0] cTxData, cRxData;
  logic       cTxValid, cTxReady, cTx, cRxValid, cRxPe, cRxFe;

  uart_core #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) uC (
    .ipClk(clk), .nReset(rst), .ipTxData(cTxData), .ipTxValid(cTxValid),
    .opTxReady(cTxReady), .opTx(cTx), .ipRx(rxLine[2]), .opRxData(cRxData),
    .opRxValid(cRxValid), .opRxParityErr(cRxPe), .opRxFrameErr(cRxFe));

  function automatic exp_t mk(input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nChk++;
    if (act === req) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
  endtask

  task automatic unexpected(input string nm, input logic [31:0] d);
    nChk++;
    $display("FAIL %s: unexpected rx pulse, data 0x%0h", nm, d);
  endtask

  // Monitors: pop the scoreboard on every received-word pulse
  always @(negedge clk) begin : monA
    exp_t e;
    if (!rst && aRxValid) begin
      pulses[0]++;
      if (qA.size() == 0) unexpected("A rx", 32'(aRxData));
      else begin
        e = qA.pop_front();
        chk("A rxData", 32'(aRxData), 32'(e.d));
        chk("A rxErr", {30'd0, aRxPe, aRxFe}, {30'd0, e.pe, e.fe});
      end
    end
  end

  always @(negedge clk) begin : monB
    exp_t e;
    if (!rst && bRxValid) begin
      pulses[1]++;
      if (qB.size() == 0) unexpected("B rx", 32'(bRxData));
      else begin
        e = qB.pop_front();
        chk("B rxData", 32'(bRxData), 32'(e.d));
        chk("B rxErr", {30'd0, bRxPe, bRxFe}, {30'd0, e.pe, e.fe});
      end
    end
  end

  always @(negedge clk) begin : monC
    exp_t e;
    if (!rst && cRxValid) begin
      pulses[2]++;
      if (qC.size() == 0) unexpected("C rx", 32'(cRxData));
      else begin
        e = qC.pop_front();
        chk("C rxData", 32'(cRxData), 32'(e.d));
        chk("C rxErr", {30'd0, cRxPe, cRxFe}, {30'd0, e.pe, e.fe});
      end
    end
  end

  // Advance n clocks; inputs then change 1 time unit after the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame on bench line ln; par < 0 means no parity bit
  task automatic rxSend(input int ln, input logic [8:0] d, input int nb,
                        input int par, input int stops);
    rxLine[ln] = 1'b0;
    tick(DIV);
    for (int i = 0; i < nb; i++) begin
      rxLine[ln] = d[i];
      tick(DIV);
    end
    if (par >= 0) begin
      rxLine[ln] = par[0];
      tick(DIV);
    end
    rxLine[ln] = 1'b1;
    tick(stops * DIV);
  endtask

  task automatic sendA(input logic [7:0] d);
    int n = 0;
    aTxData  = d;
    aTxValid = 1'b1;
    @(negedge clk);
    while (!aTxReady && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!aTxReady) unexpected("A tx handshake timeout", 32'(d));
    @(posedge clk);
    #1;
    aTxValid = 1'b0;
  endtask

  task automatic sendB(input logic [7:0] d, output int hs);
    int n = 0;
    bTxData  = d;
    bTxValid = 1'b1;
    @(negedge clk);
    while (!bTxReady && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bTxReady) unexpected("B tx handshake timeout", 32'(d));
    @(posedge clk);
    #1;
    hs       = cyc;
    bTxValid = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit expired, %0d/%0d checks passed so far", nPass, nChk);
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] v;
    int         eb, k, p, h0, h1, h2;
    rst = 1'b1;
    rxLine = 3'b111;
    aLoop = 1'b0;
    aTxData = '0; aTxValid = 1'b0;
    bTxData = '0; bTxValid = 1'b0;
    cTxData = '0; cTxValid = 1'b0;
    pulses = '{0, 0, 0};

    // Reset state
    tick(3);
    @(negedge clk);
    chk("reset opTx", 32'(aTx), 1);
    chk("reset opTxReady", 32'(aTxReady), 0);
    chk("reset opRxValid", 32'(aRxValid), 0);
    chk("reset opRxData", 32'(aRxData), 0);
    chk("reset errs", {30'd0, aRxPe, aRxFe}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready after reset", 32'(aTxReady), 1);
    chk("B ready after reset", 32'(bTxReady), 1);

    // 1. 8N1 0xA5 waveform and ready timing, cycle by cycle
    tick(1);
    v = 8'hA5;
    aTxData  = v;
    aTxValid = 1'b1;
    @(posedge clk); #1;
    aTxValid = 1'b0;
    for (int c = 1; c <= 160; c++) begin
      @(negedge clk);
      k  = (c - 1) / DIV;
      eb = (k == 0) ? 0 : (k <= 8) ? int'(v[k-1]) : 1;
      chk($sformatf("T1 tx/ready cycle %0d", c), {30'd0, aTx, aTxReady},
          {30'd0, eb[0], (c == 160)});
    end
    @(negedge clk);
    chk("T1 idle after frame", {30'd0, aTx, aTxReady}, 32'b11);

    // 2. 8E2 loopback, three back-to-back frames
    tick(1);
    qB.push_back(mk(9'h00, 1'b0, 1'b0));
    qB.push_back(mk(9'hFF, 1'b0, 1'b0));
    qB.push_back(mk(9'h81, 1'b0, 1'b0));
    sendB(8'h00, h0);
    sendB(8'hFF, h1);
    sendB(8'h81, h2);
    chk("T2 gap frame1->2", 32'(h1 - h0), 192);
    chk("T2 gap frame2->3", 32'(h2 - h1), 192);
    tick(260);
    chk("T2 pulse count", 32'(pulses[1]), 3);

    // 3. 7O1: good frame 0x2A (parity bit 0), then 0x55 with parity inverted
    qC.push_back(mk(9'h2A, 1'b0, 1'b0));
    rxSend(2, 9'h02A, 7, 0, 1);
    qC.push_back(mk(9'h55, 1'b1, 1'b0));
    rxSend(2, 9'h055, 7, 0, 1);
    tick(20);
    chk("T3 pulse count", 32'(pulses[2]), 2);

    // 4. 5-cycle glitch rejected, following 0x3C received
    p = pulses[0];
    rxLine[0] = 1'b0;
    tick(5);
    rxLine[0] = 1'b1;
    tick(40);
    chk("T4 glitch no pulse", 32'(pulses[0]), 32'(p));
    qA.push_back(mk(9'h3C, 1'b0, 1'b0));
    rxSend(0, 9'h03C, 8, -1, 1);
    tick(20);
    chk("T4 frame pulse", 32'(pulses[0]), 32'(p + 1));

    // 5. Break: one errored pulse, silence while low, recovery afterwards
    p = pulses[0];
    qA.push_back(mk(9'h00, 1'b0, 1'b1));
    rxLine[0] = 1'b0;
    tick(30 * DIV);
    chk("T5 break single pulse", 32'(pulses[0]), 32'(p + 1));
    rxLine[0] = 1'b1;
    tick(3 * DIV);
    chk("T5 no pulse on release", 32'(pulses[0]), 32'(p + 1));
    qA.push_back(mk(9'h96, 1'b0, 1'b0));
    rxSend(0, 9'h096, 8, -1, 1);
    tick(20);
    chk("T5 frame after break", 32'(pulses[0]), 32'(p + 2));

    // 6. Reset mid TX / mid RX (A looped back), then a fresh frame
    p = pulses[0];
    aLoop = 1'b1;
    tick(2);
    sendA(8'h5A);
    tick(60);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("T6 opTx in reset", 32'(aTx), 1);
    chk("T6 opRxValid in reset", 32'(aRxValid), 0);
    chk("T6 opTxReady in reset", 32'(aTxReady), 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    qA.push_back(mk(9'hC3, 1'b0, 1'b0));
    sendA(8'hC3);
    tick(200);
    chk("T6 pulse count", 32'(pulses[0]), 32'(p + 1));

    // Every expected word consumed, idle TX untouched
    chk("A queue drained", 32'(qA.size()), 0);
    chk("B queue drained", 32'(qB.size()), 0);
    chk("C queue drained", 32'(qC.size()), 0);
    chk("C tx idle", {30'd0, cTx, cTxReady}, 32'b11);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
